apb4_master_mux: RTL and testbench
==================================

Name: apb4_master_mux

Overview:
Parametrised APB4 master for multiple slaves.
- Accepts single-beat read/write commands on a valid/ready request port and runs the APB4 SETUP/ACCESS protocol with registered outputs.
- Decodes the slave index from the upper address bits, drives a one-hot PSEL vector and muxes PREADY/PRDATA/PSLVERR back.
- Returns a one-cycle response pulse per transfer.
- Sits between the system bus front-end and the APB slave cluster.

Parameters:
- DATA_WIDTH, 32, data bus width; multiple of 8.
- ADDR_WIDTH, 32, address width.
- NUM_SLAVES, 4, number of APB slaves; 1..16.
- TIMEOUT_CYCLES, 256, ACCESS-phase watchdog limit; used only with APB_TIMEOUT_EN.
- Derived localparams: STRB_WIDTH = DATA_WIDTH/8; SEL_BITS = max(1, clog2(NUM_SLAVES)).

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset, asynchronous, active-high
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when valid&ready
- req_addr  in  ADDR_WIDTH  command address
- req_write  in  1  1=write, 0=read
- req_wdata  in  DATA_WIDTH  write data
- req_strb  in  STRB_WIDTH  write strobes
- req_prot  in  3  protection attributes
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_slverr  out  1  error flag
- PADDR  out  ADDR_WIDTH  APB address
- PPROT  out  3  APB protection
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PSTRB  out  STRB_WIDTH  APB strobes
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE  out  1  APB enable
- PREADY  in  NUM_SLAVES  per-slave ready
- PRDATA  in  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE. All outputs 0: PADDR, PPROT, PWRITE, PWDATA, PSTRB, PSEL, PENABLE, rsp_valid, rsp_rdata, rsp_slverr. req_ready=0 while PRESET is high.
- Reset mid-transfer aborts it: PSEL/PENABLE drop asynchronously and no response is generated.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready=1.
  - On valid&ready, capture addr/write/wdata/prot into the APB output registers. PSTRB = req_strb if write, else 0.
  - Compute idx = req_addr[ADDR_WIDTH-1 -: SEL_BITS]; decode_err = (idx >= NUM_SLAVES).
  - PSEL[idx] <= 1 unless decode_err. Go to SETUP.
- SETUP (exactly 1 cycle): PENABLE <= 1 (visible in ACCESS). Go to ACCESS.
- ACCESS: transfer completes when PREADY[idx]=1, or immediately (first ACCESS cycle) if decode_err.
- On completion:
  - Next cycle: rsp_valid=1 for exactly one cycle.
  - rsp_rdata = PRDATA slice idx for a read without error, else 0.
  - rsp_slverr = PSLVERR[idx], or 1 on decode_err.
- Back-to-back: req_ready is also 1 in the completing ACCESS cycle.
  - If req_valid in that cycle: capture the new command and go straight to SETUP. PENABLE <= 0; PSEL switches to the new index.
  - Otherwise go to IDLE: PSEL <= 0, PENABLE <= 0.
- Signal hold rules:
  - PADDR, PWRITE, PWDATA, PSTRB, PPROT hold stable from SETUP through the end of ACCESS.
  - In IDLE they hold their last value (no toggling).
- Latency:
  - Zero wait states: request accept to rsp_valid = 3 cycles.
  - Each PREADY low cycle adds one.
- PREADY/PRDATA/PSLVERR of unselected slaves are ignored.
- Back-pressure: the response port has no ready; the consumer must always accept.

Optional Feature:
APB_TIMEOUT_EN
- Defined: a counter, cleared on entry to ACCESS, increments each ACCESS cycle with PREADY[idx]=0. When it reaches TIMEOUT_CYCLES-1 the transfer aborts:
  - PSEL/PENABLE drop next cycle and state goes to IDLE.
  - rsp_valid=1, rsp_slverr=1, rsp_rdata=0.
  - req_ready is not asserted in the abort cycle.
- Not defined: no counter is built; ACCESS waits indefinitely for PREADY.

Decomposition:
- Package apb4_pkg:
  - State enum (IDLE/SETUP/ACCESS).
  - PPROT bit constants (privileged, non-secure, instruction).
  - Default width constants.
  - Function computing SEL_BITS.
- Sub-module apb4_addr_decoder:
  - Combinational.
  - Input: address. Outputs: idx, one-hot sel vector, decode_err.
  - Instantiated once.

Test Plan:
- Single write to slave 1 (addr 0x4000_0010, wdata 0xDEADBEEF, strb 0xF), PREADY[1]=1 -> PSEL=0b0010 in SETUP with PENABLE=0. Next cycle PENABLE=1. rsp_valid 3 cycles after accept, rsp_slverr=0.
- Read from slave 2 (0x8000_0000), PREADY[2] low for 3 cycles, PRDATA slice 2=0x12345678 -> ACCESS lasts 4 cycles, PSTRB=0, rsp_rdata=0x12345678.
- NUM_SLAVES=3, addr 0xC000_0000 -> PSEL stays 0. rsp_slverr=1, rsp_rdata=0 after 3 cycles.
- Back-to-back write to slave 0 then read from slave 3 with req_valid held -> SETUP follows ACCESS directly. PENABLE deasserts for the SETUP cycle. Two rsp_valid pulses 2 cycles apart.
- PRESET asserted during ACCESS -> PSEL, PENABLE, rsp_valid go 0 immediately, no response. After release: IDLE, req_ready=1.
- With APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, PREADY stuck 0 -> abort after 8 ACCESS cycles. rsp_slverr=1, then IDLE.

Source files
------------

// File: rtl/apb4_pkg.sv
// apb4_pkg: shared types and constants for the APB4 master.
//   - apb_state_e : transfer FSM states (IDLE / SETUP / ACCESS)
//   - PPROT_*     : PPROT bit meanings (privileged, non-secure, instruction)
//   - DEF_*       : default widths and limits used as parameter defaults
//   - sel_bits()  : width of the slave-index field in the address
package apb4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [2:0] PPROT_PRIV   = 3'b001;
  localparam logic [2:0] PPROT_NONSEC = 3'b010;
  localparam logic [2:0] PPROT_INSTR  = 3'b100;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_NUM_SLAVES     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  // A single slave still needs a one-bit index field.
  function automatic int sel_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb4_addr_decoder.sv
// apb4_addr_decoder: combinational slave-index decode.
//   addr_sel   in  SEL_BITS    top SEL_BITS bits of the request address
//   idx        out SEL_BITS    slave index
//   sel        out NUM_SLAVES  one-hot select (all zero on decode error)
//   decode_err out 1           index does not map to an existing slave
// Only the select field is passed in; the rest of the address carries no
// decode information.
module apb4_addr_decoder
  import apb4_pkg::*;
#(
  parameter int NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int SEL_BITS   = sel_bits(DEF_NUM_SLAVES)
) (
  input  logic [SEL_BITS-1:0]   addr_sel,
  output logic [SEL_BITS-1:0]   idx,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  decode_err
);

  always_comb begin
    idx        = addr_sel;
    decode_err = (int'(addr_sel) >= NUM_SLAVES);
    sel        = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = !decode_err && (addr_sel == SEL_BITS'(i));
    end
  end

endmodule

// File: rtl/apb4_master_mux.sv
// apb4_master_mux: single-beat APB4 master driving NUM_SLAVES slaves.
//   PCLK/PRESET          clock, asynchronous active-high reset
//   req_*                valid/ready command port (addr, write, wdata, strb, prot)
//   rsp_*                one-cycle response pulse (rdata, slverr)
//   PADDR..PENABLE       registered APB4 request outputs, PSEL one-hot
//   PREADY/PRDATA/PSLVERR per-slave returns, muxed by the captured index
// Optional build macro APB_TIMEOUT_EN adds an ACCESS-phase watchdog of
// TIMEOUT_CYCLES cycles that aborts a stuck transfer with an error response.
module apb4_master_mux
  import apb4_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int NUM_SLAVES     = DEF_NUM_SLAVES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic                             req_write,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [DATA_WIDTH/8-1:0]          req_strb,
  input  logic [2:0]                       req_prot,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_slverr,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [2:0]                       PPROT,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SEL_BITS   = sel_bits(NUM_SLAVES);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
    $error("apb4_master_mux: NUM_SLAVES must be 1..16");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("apb4_master_mux: DATA_WIDTH must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb4_master_mux: TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_e state, state_d;

  logic [SEL_BITS-1:0]   dec_idx, idx_q;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_err, derr_q;
  logic                  sel_ready, sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  xfer_ok, abort, done, accept;

  apb4_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_BITS   (SEL_BITS)
  ) u_dec (
    .addr_sel   (req_addr[ADDR_WIDTH-1 -: SEL_BITS]),
    .idx        (dec_idx),
    .sel        (dec_sel),
    .decode_err (dec_err)
  );

  // Return-path mux keyed on the captured index; an out-of-range index
  // matches nothing, so unselected and non-existent slaves read as zero.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == SEL_BITS'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A decode error completes on the first ACCESS cycle without a slave.
  assign xfer_ok = (state == ACCESS) && (derr_q || sel_ready);

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS && !xfer_ok) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign abort = (state == ACCESS) && !xfer_ok &&
                 (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  assign done      = xfer_ok || abort;
  // Ready in the completing ACCESS cycle allows back-to-back transfers;
  // an abort cycle never accepts.
  assign req_ready = !PRESET && ((state == IDLE) || xfer_ok);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (xfer_ok)    state_d = req_valid ? SETUP : IDLE;
        else if (abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // APB request registers: loaded on accept, held otherwise.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR   <= '0;
      PPROT   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSTRB   <= '0;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      idx_q   <= '0;
      derr_q  <= 1'b0;
    end else if (accept) begin
      PADDR   <= req_addr;
      PPROT   <= req_prot;
      PWRITE  <= req_write;
      PWDATA  <= req_wdata;
      PSTRB   <= req_write ? req_strb : STRB_WIDTH'(0);
      PSEL    <= dec_sel;
      PENABLE <= 1'b0;
      idx_q   <= dec_idx;
      derr_q  <= dec_err;
    end else if (state == SETUP) begin
      PENABLE <= 1'b1;
    end else if (done) begin
      PSEL    <= '0;
      PENABLE <= 1'b0;
    end
  end

  // Response stage: one pulse the cycle after completion.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      rsp_valid  <= done;
      rsp_rdata  <= (xfer_ok && !PWRITE && !derr_q && !sel_err) ? sel_rdata : '0;
      rsp_slverr <= abort || (xfer_ok && (derr_q || sel_err));
    end
  end

endmodule

// File: tb/tb_apb4_master_mux.sv
module tb_apb4_master_mux;
  import apb4_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NS  = 3;
  localparam int TMO = 8;
  localparam int SW  = DW / 8;

  logic             PCLK = 1'b0;
  logic             PRESET = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [AW-1:0]    req_addr = '0;
  logic             req_write = 1'b0;
  logic [DW-1:0]    req_wdata = '0;
  logic [SW-1:0]    req_strb = '0;
  logic [2:0]       req_prot = '0;
  logic             rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_slverr;
  logic [AW-1:0]    PADDR;
  logic [2:0]       PPROT;
  logic             PWRITE;
  logic [DW-1:0]    PWDATA;
  logic [SW-1:0]    PSTRB;
  logic [NS-1:0]    PSEL;
  logic             PENABLE;
  logic [NS-1:0]    PREADY = '0;
  logic [NS*DW-1:0] PRDATA = '0;
  logic [NS-1:0]    PSLVERR = '0;

  always #5 PCLK = ~PCLK;

  apb4_master_mux #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .PADDR(PADDR), .PPROT(PPROT), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PSEL(PSEL), .PENABLE(PENABLE),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    int            waits;   // PREADY-low cycles the slave inserts
    logic [DW-1:0] rdata;   // data the slave returns
    logic          err;     // PSLVERR the slave returns
  } cmd_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          slverr;
    int            cyc;
  } rsp_t;

  cmd_t apb_q[$];
  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: response and its arrival cycle from the command alone.
  function automatic rsp_t model(input cmd_t c, input int acc_cyc);
    rsp_t r;
    int   idx  = int'(c.addr[AW-1 -: 2]);
    bit   derr = (idx >= NS);
    bit   tmo  = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo = !derr && (c.waits >= TMO);
`endif
    r.slverr = derr || tmo || c.err;
    r.rdata  = (!c.write && !r.slverr) ? c.rdata : '0;
    if (derr)     r.cyc = acc_cyc + 3;
    else if (tmo) r.cyc = acc_cyc + 2 + TMO;
    else          r.cyc = acc_cyc + 3 + c.waits;
    return r;
  endfunction

  function automatic cmd_t mk(input logic [AW-1:0] addr, input logic write,
                              input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                              input int waits, input logic [DW-1:0] rdata, input logic err);
    cmd_t c;
    c.addr = addr; c.write = write; c.wdata = wdata; c.strb = strb;
    c.prot = PPROT_PRIV; c.waits = waits; c.rdata = rdata; c.err = err;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.addr  = $urandom;
    c.write = 1'($urandom);
    c.wdata = $urandom;
    c.strb  = SW'($urandom);
    c.prot  = ($urandom_range(0, 1) != 0 ? PPROT_PRIV   : 3'b000) |
              ($urandom_range(0, 1) != 0 ? PPROT_NONSEC : 3'b000) |
              ($urandom_range(0, 1) != 0 ? PPROT_INSTR  : 3'b000);
    c.waits = int'($urandom_range(0, 4));
    c.rdata = $urandom;
    c.err   = ($urandom_range(0, 7) == 0);
    return c;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input cmd_t c);
    int n = 0;
    req_valid = 1'b1; req_addr = c.addr; req_write = c.write;
    req_wdata = c.wdata; req_strb = c.strb; req_prot = c.prot;
    while (!req_ready && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    n_checks++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL req_ready_wait: request not accepted within 50 cycles");
      req_valid = 1'b0;
      return;
    end
    if (int'(c.addr[AW-1 -: 2]) < NS) apb_q.push_back(c);
    exp_q.push_back(model(c, cyc));
    @(negedge PCLK);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge PCLK) begin
    if (!PRESET && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: rsp_valid with nothing expected (cycle %0d)", cyc);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_cycle",  cyc,        e.cyc);
        check("rsp_rdata",  rsp_rdata,  e.rdata);
        check("rsp_slverr", rsp_slverr, e.slverr);
      end
    end
  end

  // Slave model: unselected returns are random garbage.
  cmd_t          cur;
  int            cnt = 0;
  int            sidx = 0;
  bit            active = 1'b0;
  logic [NS-1:0] onehot;

  always @(posedge PCLK) begin
    #1;
    PREADY  = NS'($urandom);
    PRDATA  = {$urandom(), $urandom(), $urandom()};
    PSLVERR = NS'($urandom);
    if (PRESET) begin
      active = 1'b0;
    end else if (PSEL != '0 && !PENABLE) begin
      if (apb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL apb_unexpected: SETUP with PSEL=0x%0h and nothing expected", PSEL);
        active = 1'b0;
      end else begin
        cur    = apb_q.pop_front();
        active = 1'b1;
        cnt    = cur.waits;
        sidx   = int'(cur.addr[AW-1 -: 2]);
        onehot = '0;
        onehot[sidx] = 1'b1;
        check("setup_psel",   PSEL,   onehot);
        check("setup_paddr",  PADDR,  cur.addr);
        check("setup_pwrite", PWRITE, cur.write);
        check("setup_pwdata", PWDATA, cur.wdata);
        check("setup_pstrb",  PSTRB,  cur.write ? cur.strb : '0);
        check("setup_pprot",  PPROT,  cur.prot);
      end
    end else if (PSEL != '0 && PENABLE && active) begin
      check("access_hold", {PSEL, PADDR, PWRITE, PSTRB, PPROT},
            {onehot, cur.addr, cur.write, cur.write ? cur.strb : SW'(0), cur.prot});
      check("access_pwdata", PWDATA, cur.wdata);
      PREADY[sidx]              = (cnt == 0);
      PRDATA[sidx*DW +: DW]     = cur.rdata;
      PSLVERR[sidx]             = cur.err;
      if (cnt > 0) cnt--;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    // Reset state
    idle(3);
    check("reset_req_ready", req_ready, 1'b0);
    check("reset_apb", {PADDR, PPROT, PWRITE, PSTRB, PSEL, PENABLE}, '0);
    check("reset_pwdata", PWDATA, '0);
    check("reset_rsp", {rsp_valid, rsp_slverr, rsp_rdata}, '0);
    PRESET = 1'b0;
    idle(1);
    check("idle_req_ready", req_ready, 1'b1);

    // Single write to slave 1, zero wait states
    c = mk(32'h4000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
    issue(c);
    check("w1_setup_psel", PSEL, 3'b010);
    check("w1_setup_penable", PENABLE, 1'b0);
    idle(1);
    check("w1_access_penable", PENABLE, 1'b1);
    drain();

    // Read from slave 2 with 3 wait states
    c = mk(32'h8000_0000, 1'b0, 32'h0, 4'hF, 3, 32'h1234_5678, 1'b0);
    issue(c);
    drain();

    // Decode error (index 3 with 3 slaves)
    c = mk(32'hC000_0000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    issue(c);
    check("derr_psel", PSEL, '0);
    drain();

    // Slave error on a read
    c = mk(32'h0000_0040, 1'b0, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 1'b1);
    issue(c);
    drain();

    // Back-to-back: write slave 0 then read slave 2
    c = mk(32'h0000_0004, 1'b1, 32'h0BAD_F00D, 4'h3, 0, 32'h0, 1'b0);
    issue(c);
    c = mk(32'h8000_0008, 1'b0, 32'h0, 4'hF, 0, 32'h5555_AAAA, 1'b0);
    issue(c);
    check("b2b_setup_penable", PENABLE, 1'b0);
    check("b2b_setup_psel", PSEL, 3'b100);
    drain();

    // Reset during ACCESS
    c = mk(32'h8000_0100, 1'b0, 32'h0, 4'h0, 6, 32'h7777_7777, 1'b0);
    issue(c);
    idle(1);
    #2;
    PRESET = 1'b1;
    #1;
    check("rst_mid_psel", PSEL, '0);
    check("rst_mid_penable", PENABLE, 1'b0);
    check("rst_mid_rsp_valid", rsp_valid, 1'b0);
    check("rst_mid_req_ready", req_ready, 1'b0);
    exp_q.delete();
    idle(2);
    PRESET = 1'b0;
    #1;
    check("rst_rel_req_ready", req_ready, 1'b1);
    check("rst_rel_psel", PSEL, '0);
    idle(10);

`ifdef APB_TIMEOUT_EN
    // Longest wait that still completes, then one that aborts
    c = mk(32'h0000_0100, 1'b0, 32'h0, 4'h0, TMO - 1, 32'hA5A5_0007, 1'b0);
    issue(c);
    drain();
    c = mk(32'h4000_0200, 1'b0, 32'h0, 4'h0, TMO + 20, 32'hA5A5_0008, 1'b0);
    issue(c);
    drain();
    idle(1);
    check("tmo_idle_req_ready", req_ready, 1'b1);
    check("tmo_idle_psel", PSEL, '0);
`endif

    // Randomized traffic with random gaps (0 gives back-to-back)
    for (int i = 0; i < 150; i++) begin
      c = rand_cmd();
      issue(c);
      idle(int'($urandom_range(0, 2)));
    end
    drain();
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
